piradip_trigger_capture: RTL and testbench

PIRADIP_TRIGGER_CAPTURE -- requirements
Module: piradip_trigger_capture

---
 rtl/piradip_trigger_pkg.sv | 16 +
 rtl/piradip_axis_pipe_reg.sv | 45 ++++
 rtl/piradip_trigger_capture.sv | 121 ++++++++++++
 tb/tb_piradip_trigger_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piradip_trigger_pkg.sv
// Shared types for the trigger-driven stream capture block and its helpers.
package piradip_trigger_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } capState_e;

  // A frame is in flight from the first captured beat until its last beat drains.
  function automatic logic stateIsBusy(input capState_e s);
    return (s == CAPTURE) || (s == FLUSH);
  endfunction

endpackage

// File: rtl/piradip_axis_pipe_reg.sv
// Single-entry AXI-stream output register carrying data and a last flag.
// The caller only loads when the slot is empty or draining this cycle.
module piradip_axis_pipe_reg #(
  parameter int unsigned DATA_WIDTH = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  last_o
);

  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  // Payload carries no reset so it maps onto plain enable flops.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule

// File: rtl/piradip_trigger_capture.sv
// Arms on enable, captures capture_len beats of the input stream after a
// trigger rising edge, and forwards them through one output register.
module piradip_trigger_capture
  import piradip_trigger_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   trigger,
  input  logic [COUNT_WIDTH-1:0] capture_len,
  input  logic [DATA_WIDTH-1:0]  s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   busy,
  output logic                   missed
);

  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  capState_e              state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   trigPrev_q;
  logic                   missed_q, missed_d;

  logic trigRise;
  logic accept;
  logic lastBeat;

  assign trigRise = trigger & ~trigPrev_q;
  assign accept   = (state_q == CAPTURE) & s_tvalid & s_tready;
  assign lastBeat = (cnt_q == CntOne);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trigPrev_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trigPrev_q <= trigger;
      missed_q   <= missed_d;
    end
  end

  // A zero-length request never leaves ARMED; an active frame always runs
  // to completion even if enable drops, only the return target changes.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    missed_d = missed_q;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (trigRise && (capture_len != '0)) begin
          cnt_d   = capture_len;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          cnt_d = cnt_q - CntOne;
          if (lastBeat) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (m_tvalid && m_tready && m_tlast) begin
          state_d = enable ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      missed_d = 1'b0;
    end else if (trigRise && (state_q != ARMED)) begin
      missed_d = 1'b1;
    end
  end

  // Outside a frame the input is drained and discarded; inside one the
  // output register's occupancy throttles the source.
  always_comb begin
    s_tready = 1'b1;
    unique case (state_q)
      IDLE, ARMED: s_tready = 1'b1;
      CAPTURE:     s_tready = ~m_tvalid | m_tready;
      FLUSH:       s_tready = 1'b0;
      default:     s_tready = 1'b1;
    endcase
    busy   = stateIsBusy(state_q);
    missed = missed_q;
  end

  piradip_axis_pipe_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outReg (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .load_i (accept),
    .data_i (s_tdata),
    .last_i (lastBeat),
    .ready_i(m_tready),
    .valid_o(m_tvalid),
    .data_o (m_tdata),
    .last_o (m_tlast)
  );

endmodule

// File: tb/tb_piradip_trigger_capture.sv
// Scoreboard bench for piradip_trigger_capture: counting source data, table of
// capture lengths plus hand-built retrigger, enable-drop and reset sequences.
module tb_piradip_trigger_capture;
  import piradip_trigger_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          aclk;
  logic          aresetn;
  logic          enable;
  logic          trigger;
  logic [CW-1:0] capture_len;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          busy;
  logic          missed;

  piradip_trigger_capture #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .trigger    (trigger),
    .capture_len(capture_len),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast),
    .busy       (busy),
    .missed     (missed)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    int        len;
    int        readyMode;
    logic      expBusy;
    capState_e expState;
    int        expBeats;
    logic      expMissed;
  } capVec_t;

  beat_t         sb[$];
  beat_t         expBeat;
  int            errors    = 0;
  int            checks    = 0;
  int            rxCount   = 0;
  int            cycleNo   = 0;
  int            readyMode = 0;
  logic          srcFire   = 1'b0;
  logic [DW-1:0] srcCnt    = '0;
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData  = '0;
  logic          prevLast  = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Beats are scored at the falling edge; a valid&ready seen here transfers on the next rising edge.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (prevStall) begin
          checkOutput("holdValid", 64'(m_tvalid), 64'(1));
          checkOutput("holdData", 64'(m_tdata), 64'(prevData));
          checkOutput("holdLast", 64'(m_tlast), 64'(prevLast));
        end
        if (m_tvalid && !m_tready) checkOutput("backpressure s_tready", 64'(s_tready), 64'(0));
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedBeat: got data %0h last %0b, expected no beat", m_tdata, m_tlast);
          end else begin
            expBeat = sb.pop_front();
            checkOutput("beatData", 64'(m_tdata), 64'(expBeat.data));
            checkOutput("beatLast", 64'(m_tlast), 64'(expBeat.last));
          end
          rxCount++;
        end
      end
      prevStall = aresetn && m_tvalid && !m_tready;
      prevData  = m_tdata;
      prevLast  = m_tlast;
      srcFire   = aresetn && s_tvalid && s_tready;
    end
  end

  // The source holds its counting value until accepted; the sink follows the current ready pattern.
  task automatic tick();
    @(posedge aclk);
    #1;
    if (srcFire) srcCnt = srcCnt + DW'(1);
    s_tdata = srcCnt;
    cycleNo++;
    case (readyMode)
      1:       m_tready = ((cycleNo % 4) == 0) || ((cycleNo % 4) == 3);
      2:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = 1'b1;
    endcase
  endtask

  // The beat on the bus during the trigger cycle is discarded while ARMED,
  // so the frame starts with the following source value.
  task automatic applyStimulus(input int len);
    logic [DW-1:0] base;
    capture_len = CW'(len);
    trigger     = 1'b1;
    base        = s_tdata;
    for (int i = 1; i <= len; i++) begin
      sb.push_back(beat_t'{data: base + DW'(i), last: (i == len)});
    end
    tick();
    trigger = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || m_tvalid || busy) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL %s timeout: still busy after %0d cycles, expected drained", name, n);
    end
    repeat (3) tick();
  endtask

  task automatic waitBeats(input string name, input int count, input int budget);
    int n = 0;
    while (rxCount < count && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL %s timeout: got %0d beats, expected %0d", name, rxCount, count);
    end
  endtask

  capVec_t vecs[7];

  initial begin
    vecs[0] = '{len: 4,   readyMode: 0, expBusy: 1'b1, expState: CAPTURE, expBeats: 4,   expMissed: 1'b0};
    vecs[1] = '{len: 1,   readyMode: 0, expBusy: 1'b1, expState: CAPTURE, expBeats: 1,   expMissed: 1'b0};
    vecs[2] = '{len: 0,   readyMode: 0, expBusy: 1'b0, expState: ARMED,   expBeats: 0,   expMissed: 1'b0};
    vecs[3] = '{len: 8,   readyMode: 1, expBusy: 1'b1, expState: CAPTURE, expBeats: 8,   expMissed: 1'b0};
    vecs[4] = '{len: 5,   readyMode: 2, expBusy: 1'b1, expState: CAPTURE, expBeats: 5,   expMissed: 1'b0};
    vecs[5] = '{len: 3,   readyMode: 1, expBusy: 1'b1, expState: CAPTURE, expBeats: 3,   expMissed: 1'b0};
    vecs[6] = '{len: 255, readyMode: 0, expBusy: 1'b1, expState: CAPTURE, expBeats: 255, expMissed: 1'b0};

    aresetn     = 1'b1;
    enable      = 1'b0;
    trigger     = 1'b0;
    capture_len = '0;
    s_tvalid    = 1'b1;
    s_tdata     = '0;
    m_tready    = 1'b1;
    #3 aresetn  = 1'b0;
    #1;
    checkOutput("reset m_tvalid", 64'(m_tvalid), 64'(0));
    checkOutput("reset m_tlast", 64'(m_tlast), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset missed", 64'(missed), 64'(0));
    checkOutput("reset s_tready", 64'(s_tready), 64'(1));
    checkOutput("reset state", 64'(dut.state_q), 64'(IDLE));
    repeat (2) tick();
    aresetn = 1'b1;
    enable  = 1'b1;
    repeat (2) tick();
    checkOutput("armed state", 64'(dut.state_q), 64'(ARMED));

    for (int i = 0; i < 7; i++) begin
      readyMode = vecs[i].readyMode;
      rxCount   = 0;
      applyStimulus(vecs[i].len);
      checkOutput($sformatf("vec%0d busy", i), 64'(busy), 64'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d state", i), 64'(dut.state_q), 64'(vecs[i].expState));
      waitDrain($sformatf("vec%0d", i), 700);
      checkOutput($sformatf("vec%0d beats", i), 64'(rxCount), 64'(vecs[i].expBeats));
      checkOutput($sformatf("vec%0d missed", i), 64'(missed), 64'(vecs[i].expMissed));
      checkOutput($sformatf("vec%0d busyAfter", i), 64'(busy), 64'(0));
      checkOutput($sformatf("vec%0d stateAfter", i), 64'(dut.state_q), 64'(ARMED));
    end

    // Second trigger two cycles into a 16-beat frame is ignored but flagged.
    readyMode = 0;
    rxCount   = 0;
    applyStimulus(16);
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checkOutput("retrigger missed", 64'(missed), 64'(1));
    waitDrain("retrigger", 200);
    checkOutput("retrigger beats", 64'(rxCount), 64'(16));
    checkOutput("retrigger missedSticky", 64'(missed), 64'(1));
    enable = 1'b0;
    tick();
    checkOutput("retrigger missedCleared", 64'(missed), 64'(0));
    enable = 1'b1;
    repeat (2) tick();

    // Dropping enable mid-frame still delivers all ten beats, then idles.
    rxCount = 0;
    applyStimulus(10);
    waitBeats("enableDrop", 3, 100);
    enable = 1'b0;
    waitDrain("enableDrop", 200);
    checkOutput("enableDrop beats", 64'(rxCount), 64'(10));
    checkOutput("enableDrop busy", 64'(busy), 64'(0));
    checkOutput("enableDrop state", 64'(dut.state_q), 64'(IDLE));
    capture_len = CW'(4);
    trigger     = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (10) tick();
    checkOutput("enableDrop noCapture", 64'(rxCount), 64'(10));
    checkOutput("enableDrop idleBusy", 64'(busy), 64'(0));
    enable = 1'b1;
    repeat (2) tick();

    // Reset during beat five of ten discards the frame; the next one is clean.
    readyMode = 1;
    rxCount   = 0;
    applyStimulus(10);
    waitBeats("resetMid", 4, 100);
    @(negedge aclk);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("resetMid m_tvalid", 64'(m_tvalid), 64'(0));
    checkOutput("resetMid busy", 64'(busy), 64'(0));
    checkOutput("resetMid s_tready", 64'(s_tready), 64'(1));
    sb.delete();
    repeat (2) tick();
    aresetn = 1'b1;
    rxCount = 0;
    repeat (5) tick();
    checkOutput("resetMid noResidual", 64'(rxCount), 64'(0));
    checkOutput("resetMid state", 64'(dut.state_q), 64'(ARMED));
    applyStimulus(10);
    waitDrain("resetMid", 200);
    checkOutput("resetMid beats", 64'(rxCount), 64'(10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
